// File: rtl/hwpe_stream_unfence_if.sv
// HWPE-Stream handshake bundle: valid/ready with data and byte strobes.
// The master drives the payload; the slave returns ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (
        output valid, data, strb,
        input  ready
    );

    modport slave (
        input  valid, data, strb,
        output ready
    );
endinterface

// File: rtl/hwpe_stream_unfence.sv
// Splits one wide stream into NB_STREAMS narrow lanes that drain independently;
// a new wide beat is taken only once every lane has drained, or drains this cycle.
module hwpe_stream_unfence #(
    parameter int unsigned NB_STREAMS = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   test_mode_i,
    hwpe_stream_intf_stream.slave  push_i,
    hwpe_stream_intf_stream.master pop_o [NB_STREAMS-1:0],
    output logic [NB_STREAMS-1:0]  pending_o
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NB_STREAMS-1:0]                 r_pending;
    logic [NB_STREAMS-1:0][DATA_WIDTH-1:0] r_data;
    logic [NB_STREAMS-1:0][STRB_WIDTH-1:0] r_strb;

    logic [NB_STREAMS-1:0] w_pop_ready;
    logic [NB_STREAMS-1:0] w_drain;
    logic                  w_push_ready;
    logic                  w_load;
    logic                  w_unused_test_mode;

    assign w_unused_test_mode = test_mode_i;

    for (genvar i = 0; i < NB_STREAMS; i++) begin : g_lane
        assign w_pop_ready[i]  = pop_o[i].ready;
        assign pop_o[i].valid  = r_pending[i];
        assign pop_o[i].data   = r_data[i];
        assign pop_o[i].strb   = r_strb[i];
    end

    assign w_drain      = r_pending & w_pop_ready;
    // Ready depends only on lane state and pop readies, never on push valid.
    assign w_push_ready = &(~r_pending | w_pop_ready);
    assign w_load       = push_i.valid & w_push_ready;

    assign push_i.ready = w_push_ready;
    assign pending_o    = r_pending;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else if (clear_i) begin
            r_pending <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else if (w_load) begin
            r_pending <= '1;
            r_data    <= push_i.data;
            r_strb    <= push_i.strb;
        end else begin
            r_pending <= r_pending & ~w_drain;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_unfence.sv
// Directed and randomized-ready checks of the wide-to-narrow unfence with NB=2, DW=16.
module tb_hwpe_stream_unfence;
    localparam int unsigned NB = 2;
    localparam int unsigned DW = 16;
    localparam int unsigned N_RND = 300;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic test_mode_i = 1'b0;
    logic [NB-1:0] pending;

    logic        pv = 1'b0;
    logic [31:0] pdata = '0;
    logic [3:0]  pstrb = '0;
    logic        r0 = 1'b0;
    logic        r1 = 1'b0;
    logic        push_ready;
    logic        v0, v1;
    logic [15:0] d0, d1;
    logic [1:0]  s0, s1;

    int unsigned n_err = 0;
    int unsigned n_chk = 0;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(NB*DW)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW))    pop [NB-1:0] ();

    assign push.valid   = pv;
    assign push.data    = pdata;
    assign push.strb    = pstrb;
    assign push_ready   = push.ready;
    assign pop[0].ready = r0;
    assign pop[1].ready = r1;
    assign v0 = pop[0].valid;
    assign v1 = pop[1].valid;
    assign d0 = pop[0].data;
    assign d1 = pop[1].data;
    assign s0 = pop[0].strb;
    assign s1 = pop[1].strb;

    hwpe_stream_unfence #(
        .NB_STREAMS(NB),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .test_mode_i(test_mode_i),
        .push_i     (push),
        .pop_o      (pop),
        .pending_o  (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned pushed = 0;
        int unsigned pop_n0 = 0;
        int unsigned pop_n1 = 0;
        logic        held0 = 1'b0;
        logic        held1 = 1'b0;
        logic [15:0] hold0 = '0;
        logic [15:0] hold1 = '0;

        // reset state
        step(); step();
        check("rst pending", 32'(pending), 32'h0);
        check("rst valid0", 32'(v0), 32'h0);
        check("rst valid1", 32'(v1), 32'h0);
        check("rst data0", 32'(d0), 32'h0);
        check("rst strb1", 32'(s1), 32'h0);
        check("rst push_ready", 32'(push_ready), 32'h1);
        rst_ni = 1'b1;

        // basic beat and back-to-back
        pv = 1'b1; pdata = 32'hBBBB_AAAA; pstrb = 4'hF; r0 = 1'b1; r1 = 1'b1;
        step();
        check("b2b pending", 32'(pending), 32'h3);
        check("b2b data0", 32'(d0), 32'hAAAA);
        check("b2b data1", 32'(d1), 32'hBBBB);
        pdata = 32'h2222_1111;
        #1 check("b2b push_ready", 32'(push_ready), 32'h1);
        step();
        check("b2b2 data0", 32'(d0), 32'h1111);
        check("b2b2 data1", 32'(d1), 32'h2222);
        check("b2b2 pending", 32'(pending), 32'h3);
        pv = 1'b0;
        step();
        check("b2b drained", 32'(pending), 32'h0);

        // slow lane 1 stalls push only
        pv = 1'b1; pdata = 32'h4444_3333; r0 = 1'b1; r1 = 1'b0;
        step();
        check("stall data0", 32'(d0), 32'h3333);
        check("stall data1", 32'(d1), 32'h4444);
        pdata = 32'h6666_5555;
        #1 check("stall push_ready", 32'(push_ready), 32'h0);
        step();
        check("stall pending a", 32'(pending), 32'h2);
        check("stall valid0", 32'(v0), 32'h0);
        check("stall data1 a", 32'(d1), 32'h4444);
        step();
        check("stall pending b", 32'(pending), 32'h2);
        check("stall data1 b", 32'(d1), 32'h4444);
        check("stall push_ready b", 32'(push_ready), 32'h0);
        r1 = 1'b1;
        #1 check("unstall push_ready", 32'(push_ready), 32'h1);
        step();
        check("nobubble pending", 32'(pending), 32'h3);
        check("nobubble data0", 32'(d0), 32'h5555);
        check("nobubble data1", 32'(d1), 32'h6666);
        pv = 1'b0;
        step();
        check("nobubble drained", 32'(pending), 32'h0);

        // clear drops held beat and wins over push
        pv = 1'b1; pdata = 32'h8888_7777; r0 = 1'b0; r1 = 1'b0;
        step();
        check("clr pre pending", 32'(pending), 32'h3);
        pv = 1'b0; clear_i = 1'b1;
        step();
        check("clr pending", 32'(pending), 32'h0);
        check("clr valid0", 32'(v0), 32'h0);
        check("clr data0", 32'(d0), 32'h0);
        check("clr data1", 32'(d1), 32'h0);
        pv = 1'b1; pdata = 32'hAAAA_9999;
        step();
        check("clr prio pending", 32'(pending), 32'h0);
        clear_i = 1'b0;
        #1 check("clr push_ready", 32'(push_ready), 32'h1);
        step();
        check("post clr pending", 32'(pending), 32'h3);
        check("post clr data0", 32'(d0), 32'h9999);
        check("post clr data1", 32'(d1), 32'hAAAA);
        pv = 1'b0; r0 = 1'b1; r1 = 1'b1;
        step();

        // strobe split
        pv = 1'b1; pdata = 32'h1234_5678; pstrb = 4'b0110;
        step();
        check("strb lane0", 32'(s0), 32'h2);
        check("strb lane1", 32'(s1), 32'h1);
        pv = 1'b0;
        step();

        // async reset mid-transfer
        pv = 1'b1; pdata = 32'hDEAD_BEEF; pstrb = 4'hF; r0 = 1'b0; r1 = 1'b0;
        step();
        check("arst pre pending", 32'(pending), 32'h3);
        pv = 1'b0; rst_ni = 1'b0;
        #1;
        check("arst pending", 32'(pending), 32'h0);
        check("arst valid1", 32'(v1), 32'h0);
        check("arst data1", 32'(d1), 32'h0);
        #1 rst_ni = 1'b1;
        step();

        // random per-lane ready with scoreboard and stability checks
        for (int cyc = 0; cyc < 20000 && !(pop_n0 == N_RND && pop_n1 == N_RND); cyc++) begin
            if (held0) begin
                check("rnd hold valid0", 32'(v0), 32'h1);
                check("rnd hold data0", 32'(d0), 32'(hold0));
            end
            if (held1) begin
                check("rnd hold valid1", 32'(v1), 32'h1);
                check("rnd hold data1", 32'(d1), 32'(hold1));
            end
            pv    = (pushed < N_RND);
            pdata = {16'hC000 ^ pushed[15:0], pushed[15:0]};
            pstrb = 4'hF;
            r0    = 1'($urandom_range(0, 1));
            r1    = 1'($urandom_range(0, 1));
            #1;
            if (pv && push_ready) pushed++;
            held0 = v0 && !r0;
            held1 = v1 && !r1;
            hold0 = d0;
            hold1 = d1;
            if (v0 && r0) begin
                check("rnd lane0", 32'(d0), 32'(pop_n0[15:0]));
                pop_n0++;
            end
            if (v1 && r1) begin
                check("rnd lane1", 32'(d1), 32'(16'hC000 ^ pop_n1[15:0]));
                pop_n1++;
            end
            @(posedge clk);
            #1;
        end
        check("rnd count0", pop_n0, N_RND);
        check("rnd count1", pop_n1, N_RND);
        check("rnd idle", 32'(pending), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
